// File: rtl/light_output_monitor.sv
// rtl/light_output_monitor.sv - light conflict monitor and LED output stage (optional LIGHT_MON_FLASH_EN)
module light_output_monitor #(
    parameter int FAULT_FILTER = 4,
    parameter int INIT_CYCLES  = 16,
    parameter int FLASH_HALF   = 50_000_000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [2:0] main_in,
    input  logic [2:0] side_in,
    input  logic       walk_in,
    output logic [2:0] main_out,
    output logic [2:0] side_out,
    output logic       walk_out,
    output logic       fault,
    output logic [1:0] fault_code
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_PASS,
        ST_SUSPECT,
        ST_FAILSAFE
    } state_t;

    localparam logic [7:0]  FILTER_LIM = 8'(FAULT_FILTER);
    localparam logic [15:0] INIT_LAST  = 16'(INIT_CYCLES - 1);
    localparam logic [2:0]  RED        = 3'b100;

    if (FAULT_FILTER < 1 || FAULT_FILTER > 255) begin : g_bad_filter
        $error("FAULT_FILTER must be 1..255");
    end
    if (INIT_CYCLES < 1 || INIT_CYCLES > 65535) begin : g_bad_init
        $error("INIT_CYCLES must be 1..65535");
    end
    if (FLASH_HALF < 1) begin : g_bad_flash
        $error("FLASH_HALF must be at least 1");
    end

    state_t      state;
    state_t      state_next;
    logic [6:0]  sync1;
    logic [6:0]  sync2;
    logic [2:0]  smain;
    logic [2:0]  sside;
    logic        swalk;
    logic [1:0]  code;
    logic        illegal;
    logic [15:0] init_cnt;
    logic [15:0] init_next;
    logic [7:0]  filt_cnt;
    logic [7:0]  filt_next;
    logic [7:0]  filt_inc;
    logic        load_out;
    logic        enter_fail;
    logic        red_next;

    // Two-flop synchroniser for the asynchronous decoder outputs
    always_ff @(posedge clock) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {main_in, side_in, walk_in};
            sync2 <= sync1;
        end
    end

    assign smain = sync2[6:4];
    assign sside = sync2[3:1];
    assign swalk = sync2[0];

    function automatic logic one_hot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    // Classify the current sample; first matching rule sets the cause code
    always_comb begin
        code = 2'b00;
        if (!one_hot3(smain) || !one_hot3(sside)) begin
            code = 2'b01;
        end else if (!smain[2] && !sside[2]) begin
            code = 2'b10;
        end else if (swalk && !(smain[2] && sside[2])) begin
            code = 2'b11;
        end
    end

    assign illegal  = (code != 2'b00);
    assign filt_inc = (filt_cnt == 8'hFF) ? 8'hFF : filt_cnt + 8'd1;

    // State register and the counters that travel with it
    always_ff @(posedge clock) begin
        if (!rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            filt_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_next;
            filt_cnt <= filt_next;
        end
    end

    // Next-state logic: all-red hold, pass-through, glitch filtering, latched fail-safe
    always_comb begin
        state_next = state;
        init_next  = init_cnt;
        filt_next  = filt_cnt;
        load_out   = 1'b0;
        enter_fail = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_next = ST_PASS;
                end else begin
                    init_next = init_cnt + 16'd1;
                end
            end
            ST_PASS, ST_SUSPECT: begin
                if (illegal) begin
                    filt_next = filt_inc;
                    if (filt_inc >= FILTER_LIM) begin
                        state_next = ST_FAILSAFE;
                        enter_fail = 1'b1;
                    end else begin
                        state_next = ST_SUSPECT;
                    end
                end else begin
                    state_next = ST_PASS;
                    filt_next  = '0;
                    load_out   = 1'b1;
                end
            end
            default: begin
                state_next = ST_FAILSAFE;
            end
        endcase
    end

`ifdef LIGHT_MON_FLASH_EN
    localparam int FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_HALF - 1);

    logic [FLASH_W-1:0] flash_cnt;
    logic               flash_phase;
    logic               flash_wrap;

    assign flash_wrap = (flash_cnt == FLASH_LAST);

    // Flash timebase only runs in fail-safe, so the on phase always begins at entry
    always_ff @(posedge clock) begin
        if (!rst) begin
            flash_cnt   <= '0;
            flash_phase <= 1'b1;
        end else if (state == ST_FAILSAFE) begin
            if (flash_wrap) begin
                flash_cnt   <= '0;
                flash_phase <= ~flash_phase;
            end else begin
                flash_cnt <= flash_cnt + 1'b1;
            end
        end
    end

    assign red_next = (state == ST_FAILSAFE && flash_wrap) ? ~flash_phase : flash_phase;
`else
    assign red_next = 1'b1;
`endif

    // Registered LED drive and latched fault indication
    always_ff @(posedge clock) begin
        if (!rst) begin
            main_out   <= RED;
            side_out   <= RED;
            walk_out   <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else if (enter_fail || state == ST_FAILSAFE) begin
            main_out <= {red_next, 2'b00};
            side_out <= {red_next, 2'b00};
            walk_out <= 1'b0;
            if (enter_fail) begin
                fault      <= 1'b1;
                fault_code <= code;
            end
        end else if (load_out) begin
            main_out <= smain;
            side_out <= sside;
            walk_out <= swalk;
        end
    end

endmodule
